smg_scan_ctrl: RTL and testbench
================================

Name: smg_scan_ctrl

Overview:
Parametrised multi-digit seven-segment scan controller, the successor to the fixed 6-digit state-driven nibble selector. It owns its own scan timing (prescaler plus digit index) and latches the display word once per frame so digits never tear. It adds leading-zero blanking and per-digit blinking. It drives the digit-select lines and the BCD/hex nibble that feed the segment decoder.

Parameters:
DIGITS, 6, number of digits scanned (1..16); index 0 is the most significant nibble
SCAN_DIV, 50000, clk cycles each digit is held (>=1)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable
number_sig  in  4*DIGITS  display word; digit i = number_sig[4*(DIGITS-i)-1 -: 4]
blank_lz  in  1  enable leading-zero suppression
blink_mask  in  DIGITS  bit i=1: digit i blinks
dig_sel  out  DIGITS  one-hot active-high digit select; bit i = digit i
number_data  out  4  nibble for the selected digit
blank  out  1  1 = segments must be dark this cycle
frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset: rst_n low asynchronously forces dig_sel=0, number_data=0, blank=1, frame_tick=0. All internal state clears: prescaler=0, index=0, shadow=0, running=0, blink_phase=0, frame count=0.
- Start: the first clock with en=1 and running=0 loads shadow<=number_sig, sets running<=1, prescaler<=0 and index<=0.
- Running: the prescaler counts 0..SCAN_DIV-1. At terminal count it returns to 0 and index advances.
- Index wrap: DIGITS-1 wraps to 0. On that same edge, shadow<=number_sig and frame_tick pulses for one cycle.
- Hold time: each digit is held exactly SCAN_DIV cycles, so one frame is DIGITS*SCAN_DIV cycles. SCAN_DIV=1 advances every cycle. DIGITS=1 wraps every SCAN_DIV cycles.
- Outputs: registered. They reflect index, shadow and the blank terms one cycle after those change, so latency is 1 clk.
  - dig_sel = onehot(index) while running.
  - number_data = shadow nibble of index, forced to 0 when blank=1.
- Leading-zero blank: digit i is blanked if blank_lz=1 and shadow nibbles 0..i are all zero. The last digit (index DIGITS-1) is never LZ-blanked. Nibbles A–F pass through unmodified.
- Blink: blink_phase toggles after every BLINK_FRAMES frame wraps. Digit i is blanked while blink_mask[i]=1 and blink_phase=1.
- blank = LZ-blank OR blink-blank OR not running.
- blank_lz and blink_mask are sampled live each cycle, not shadowed.
- en dropping to 0 (any point in a frame): the next clock sets running=0, dig_sel=0, blank=1, number_data=0, prescaler=0 and index=0. blink_phase and the frame count hold. Re-enable restarts from the Start rule.
- number_sig changes mid-frame have no effect until the next wrap or start.
- Simultaneous en rise and wrap cannot occur, because a wrap needs running=1.

Decomposition:
- Package smg_pkg holds the default constants (SMG_DIGITS_DEF, SMG_SCAN_DIV_DEF, SMG_BLINK_FRAMES_DEF) and a nibble-extract function.
- Sub-module smg_prescaler(clk, rst_n, clr, tick), parameter DIV: counter with a terminal-count tick output. It is instantiated once for the digit scan. The blink frame counter stays inline.

Test Plan:
All scenarios use DIGITS=6, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset: assert rst_n=0 mid-frame -> immediately dig_sel=0, blank=1, number_data=0, frame_tick=0.
- Basic scan: en=1, number_sig=24'h123456, blank_lz=0.
  - From 1 clk after the start edge: dig_sel=000001 with data 1 for 4 cycles, then 000010 with data 2, and so on, up to 100000 with data 6.
  - frame_tick pulses 24 cycles after start; the pattern then repeats.
- Tear-free: change number_sig to 24'h999999 during digit 2 -> digits 2–5 still show 3,4,5,6; the next frame shows all 9s.
- Leading-zero blanking, blank_lz=1:
  - number_sig=24'h000705 -> digits 0–2 have blank=1 and data 0; digit 3 shows 7, digit 4 shows 0 (blank=0), digit 5 shows 5.
  - number_sig=0 -> only digit 5 is unblanked and shows 0.
- Blink: blink_mask=6'b000001 -> digit 0 is unblanked in frames 0–1, blanked in frames 2–3, unblanked in frames 4–5. Other digits are never blanked.
- Enable drop and restart:
  - en=0 during digit 3 -> next cycle dig_sel=0 and blank=1.
  - en=1 again -> restarts at digit 0 with a freshly loaded shadow and a full 4-cycle dwell.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared defaults and helpers for the seven-segment scan controller.
package smg_pkg;

  localparam int SMG_DIGITS_DEF       = 6;
  localparam int SMG_SCAN_DIV_DEF     = 50000;
  localparam int SMG_BLINK_FRAMES_DEF = 64;

  // Digit 0 is the most significant nibble of a DIGITS-wide word.
  function automatic logic [3:0] smg_nibble(input logic [63:0] word,
                                            input int          digits,
                                            input int          idx);
    logic [63:0] sh;
    sh = word >> (4 * (digits - 1 - idx));
    return sh[3:0];
  endfunction

endpackage

// File: rtl/smg_prescaler.sv
// Free-running divide-by-DIV counter; tick is high on the terminal count.
module smg_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Multi-digit scan controller: frame-latched display word, leading-zero
// blanking and per-digit blinking; outputs registered one clock after state.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int DIGITS       = SMG_DIGITS_DEF,
  parameter int SCAN_DIV     = SMG_SCAN_DIV_DEF,
  parameter int BLINK_FRAMES = SMG_BLINK_FRAMES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   number_sig,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [3:0]            number_data,
  output logic                  blank,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  logic                  running;
  logic [IDX_W-1:0]      idx;
  logic [4*DIGITS-1:0]   shadow;
  logic                  blink_phase;
  logic [FRM_W-1:0]      frm_cnt;
  logic                  active, scan_tick, wrap;

  logic [DIGITS-1:0]     sel_oh;
  logic [3:0]            cur_nib;
  logic                  lz_zero, lz_blank, bk_blank, blank_c;

  assign active = running & en;
  assign wrap   = active & scan_tick & (idx == LAST);

  smg_prescaler #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~active),
    .tick  (scan_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      idx     <= '0;
      shadow  <= '0;
    end else if (!en) begin
      running <= 1'b0;
      idx     <= '0;
    end else if (!running) begin
      running <= 1'b1;
      idx     <= '0;
      shadow  <= number_sig;
    end else if (scan_tick) begin
      if (idx == LAST) begin
        idx    <= '0;
        shadow <= number_sig;
      end else begin
        idx    <= idx + IDX_W'(1);
      end
    end
  end

  // Blink phase and its frame counter survive an enable drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frm_cnt     <= frm_cnt + FRM_W'(1);
      end
    end
  end

  always_comb begin
    sel_oh  = '0;
    sel_oh[0] = 1'b1;
    sel_oh  = sel_oh << idx;
    cur_nib = smg_nibble(64'(shadow), DIGITS, int'(idx));
    lz_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (i <= int'(idx))
        lz_zero = lz_zero & (smg_nibble(64'(shadow), DIGITS, i) == 4'h0);
    lz_blank = blank_lz & lz_zero & (idx != LAST);
    bk_blank = (|(blink_mask & sel_oh)) & blink_phase;
    blank_c  = lz_blank | bk_blank;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel     <= '0;
      number_data <= 4'h0;
      blank       <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (!active) begin
        dig_sel     <= '0;
        number_data <= 4'h0;
        blank       <= 1'b1;
      end else begin
        dig_sel     <= sel_oh;
        number_data <= blank_c ? 4'h0 : cur_nib;
        blank       <= blank_c;
      end
    end
  end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Randomized + directed bench for smg_scan_ctrl against a cycle-count model.
module tb_smg_scan_ctrl;

  localparam int D  = 6;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = D * SD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [23:0]   number_sig;
  logic          blank_lz;
  logic [5:0]    blink_mask;
  logic [5:0]    dig_sel;
  logic [3:0]    number_data;
  logic          blank;
  logic          frame_tick;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: time since start edge, frame-latched word, total frame wraps.
  bit          m_run;
  int          m_t;
  logic [23:0] m_sh;
  int          m_frames;

  smg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .number_sig  (number_sig),
    .blank_lz    (blank_lz),
    .blink_mask  (blink_mask),
    .dig_sel     (dig_sel),
    .number_data (number_data),
    .blank       (blank),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_sh = '0; m_frames = 0;
  endtask

  // One clock: predict from pre-edge model state and inputs, then compare.
  task automatic step();
    logic [5:0]  e_dig;
    logic [3:0]  e_dat;
    logic        e_blk, e_ft, lz, bk, wr;
    logic [23:0] tail;
    int          d;
    e_dig = '0; e_dat = 4'h0; e_blk = 1'b1; e_ft = 1'b0;
    if (!en) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0; m_sh = number_sig;
    end else begin
      d     = (m_t / SD) % D;
      tail  = m_sh >> (4 * (D - 1 - d));
      lz    = blank_lz && (d != D - 1) && (tail == 0);
      bk    = blink_mask[d] && (((m_frames / BF) % 2) == 1);
      e_blk = lz | bk;
      e_dig = 6'(1 << d);
      e_dat = e_blk ? 4'h0 : tail[3:0];
      wr    = (m_t % FRAME) == FRAME - 1;
      e_ft  = wr;
      m_t++;
      if (wr) begin
        m_frames++;
        m_sh = number_sig;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("dig_sel",     32'(dig_sel),     32'(e_dig));
    chk("number_data", 32'(number_data), 32'(e_dat));
    chk("blank",       32'(blank),       32'(e_blk));
    chk("frame_tick",  32'(frame_tick),  32'(e_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [23:0] rand_word();
    logic [23:0] v;
    v = 24'($urandom);
    return v >> (4 * $urandom_range(0, 6));
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; number_sig = '0; blank_lz = 1'b0; blink_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dig_sel", 32'(dig_sel), 32'h0);
    chk("rst_blank",   32'(blank),   32'h1);
    chk("rst_data",    32'(number_data), 32'h0);
    chk("rst_ftick",   32'(frame_tick),  32'h0);
    rst_n = 1'b1;

    // Basic scan, then tear-free update during digit 2
    en = 1'b1; number_sig = 24'h123456;
    run(10);
    number_sig = 24'h999999;
    run(50);

    // Leading-zero blanking
    blank_lz = 1'b1; number_sig = 24'h000705;
    run(40);
    number_sig = 24'h000000;
    run(40);

    // Blink digit 0 across several frames
    blank_lz = 1'b0; number_sig = 24'h123456; blink_mask = 6'b000001;
    run(6 * FRAME);

    // Enable drop during digit 3, then restart with a new word
    for (int k = 0; k < 2 * FRAME && !((m_t / SD) % D == 3 && m_t % SD == 1); k++) step();
    en = 1'b0;
    run(3);
    number_sig = 24'hABCDEF; en = 1'b1;
    run(30);

    // Asynchronous reset mid-frame
    run(7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dig_sel", 32'(dig_sel),     32'h0);
    chk("arst_blank",   32'(blank),       32'h1);
    chk("arst_data",    32'(number_data), 32'h0);
    chk("arst_ftick",   32'(frame_tick),  32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(30);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 29) == 0) number_sig = rand_word();
      if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 49) == 0) blink_mask = 6'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
